// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared 640x480 frame-buffer geometry, address helper and writer states
package fb_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int ADDR_W   = 19;
  localparam int PIX_W    = 12;
  localparam int ROW_W    = 9;
  localparam int COL_W    = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2,
    FLUSH    = 2'd3
  } wr_state_t;

  // 640*row + col built as (row<<9) + (row<<7) + col, no multiplier
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col);
    logic [ADDR_W-1:0] r;
    r = ADDR_W'(row);
    return (r << 9) + (r << 7) + ADDR_W'(col);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered occupancy, full and empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers define what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/fb_pixel_writer.sv
// rtl/fb_pixel_writer.sv - captures an RGB pixel stream into the row-major frame buffer
module fb_pixel_writer #(
  parameter int V_ACTIVE   = fb_pkg::V_ACTIVE,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      CLK100MHZ,
  input  logic                      rst,
  input  logic                      arm,
  input  logic                      continuous,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [fb_pkg::PIX_W-1:0]  s_data,
  input  logic                      s_sof,
  input  logic                      s_eol,
  output logic                      wr_en,
  output logic [fb_pkg::ADDR_W-1:0] waddr,
  output logic [fb_pkg::PIX_W-1:0]  wdata,
  input  logic                      wr_ready,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      err_short,
  output logic                      err_long,
  output logic                      err_frame,
  input  logic                      clr_err
);
  import fb_pkg::*;

  localparam int                ENTRY_W  = ADDR_W + PIX_W;
  localparam logic [COL_W-1:0]  COL_END  = COL_W'(H_ACTIVE);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(V_ACTIVE - 1);

  wr_state_t          state;
  wr_state_t          state_nxt;
  logic [ROW_W-1:0]   row;
  logic [ROW_W-1:0]   row_nxt;
  logic [COL_W-1:0]   col;
  logic [COL_W-1:0]   col_nxt;
  logic [ROW_W-1:0]   cur_row;
  logic [COL_W-1:0]   cur_col;
  logic               accept;
  logic               restart;
  logic               push;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               set_short;
  logic               set_long;
  logic               set_frame;
  logic               done_nxt;

  assign accept    = s_valid && s_ready;
  assign busy      = (state != IDLE);
  assign push_data = {pix_addr(cur_row, cur_col), s_data};

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    s_ready   = 1'b0;
    restart   = 1'b0;
    push      = 1'b0;
    set_short = 1'b0;
    set_long  = 1'b0;
    set_frame = 1'b0;
    done_nxt  = 1'b0;
    cur_row   = row;
    cur_col   = col;

    unique case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (arm || continuous) state_nxt = WAIT_SOF;
      end
      WAIT_SOF: begin
        s_ready = 1'b1;
        restart = accept && s_sof;
      end
      CAPTURE: begin
        s_ready   = !fifo_full;
        restart   = accept && s_sof;
        set_frame = restart;
      end
      FLUSH: begin
        if (fifo_empty) begin
          done_nxt  = 1'b1;
          state_nxt = continuous ? WAIT_SOF : IDLE;
        end
      end
    endcase

    // A start-of-frame beat always lands at pixel (0,0), whatever came before
    if (restart) begin
      cur_row = '0;
      cur_col = '0;
    end

    if (accept && (restart || state == CAPTURE)) begin
      state_nxt = CAPTURE;
      push      = (cur_col < COL_END);
      set_long  = !push;
      if (s_eol) begin
        set_short = (cur_col < LAST_COL);
        col_nxt   = '0;
        if (cur_row == LAST_ROW) begin
          row_nxt   = '0;
          state_nxt = FLUSH;
        end else begin
          row_nxt = cur_row + 1'b1;
        end
      end else begin
        row_nxt = cur_row;
        col_nxt = push ? cur_col + 1'b1 : cur_col;
      end
    end

    s_ready = s_ready && rst;
  end

  always_ff @(posedge CLK100MHZ or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge CLK100MHZ or negedge rst) begin
    if (!rst) begin
      row        <= '0;
      col        <= '0;
      frame_done <= 1'b0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      row        <= row_nxt;
      col        <= col_nxt;
      frame_done <= done_nxt;
      err_short  <= (err_short && !clr_err) || set_short;
      err_long   <= (err_long  && !clr_err) || set_long;
      err_frame  <= (err_frame && !clr_err) || set_frame;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK100MHZ),
    .rst_n     (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (wr_ready),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wr_en          = !fifo_empty;
  assign {waddr, wdata} = fifo_empty ? '0 : fifo_head;
endmodule

// File: tb/tb_fb_pixel_writer.sv
// tb/tb_fb_pixel_writer.sv - self-checking bench for fb_pixel_writer
module tb_fb_pixel_writer;
  import fb_pkg::*;

  localparam int LINES = 12;
  localparam int H     = 640;

  logic        clk = 1'b0;
  logic        rst, arm, continuous, s_valid, s_sof, s_eol, wr_ready, clr_err;
  logic [11:0] s_data;
  logic        s_ready, wr_en, busy, frame_done, err_short, err_long, err_frame;
  logic [18:0] waddr;
  logic [11:0] wdata;

  fb_pixel_writer #(.V_ACTIVE(LINES), .FIFO_DEPTH(4)) dut (
    .CLK100MHZ(clk), .rst(rst), .arm(arm), .continuous(continuous),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol),
    .wr_en(wr_en), .waddr(waddr), .wdata(wdata), .wr_ready(wr_ready),
    .busy(busy), .frame_done(frame_done), .err_short(err_short), .err_long(err_long),
    .err_frame(err_frame), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int cyc = 0, wr_mode = 0, wr_count = 0, last_waddr = -1, done_count = 0, ready_low = 0;
  int          exp_addr_q[$];
  logic [11:0] exp_data_q[$];

  // Reference model: frame position as plain integers, expected writes as 640*row+col
  bit m_cap, m_armed, m_short, m_long, m_frame;
  int m_r, m_c;

  typedef struct { bit arm; bit valid; bit sof; bit exp_ready; bit exp_busy; bit exp_wr; } vec_t;
  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic void model_beat(input logic [11:0] d, input bit sof, input bit eol);
    if (sof && (m_cap || m_armed)) begin
      if (m_cap) m_frame = 1'b1;
      m_cap = 1'b1; m_armed = 1'b0; m_r = 0; m_c = 0;
    end
    if (!m_cap) return;
    if (m_c < H) begin
      exp_addr_q.push_back(H * m_r + m_c);
      exp_data_q.push_back(d);
    end else m_long = 1'b1;
    if (eol) begin
      if (m_c < H - 1) m_short = 1'b1;
      if (m_r == LINES - 1) begin m_cap = 1'b0; m_armed = continuous; end
      else begin m_r++; m_c = 0; end
    end else m_c++;
  endfunction

  // Write-port monitor and wr_ready pattern generator
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      case (wr_mode)
        0:       wr_ready = 1'b1;
        1:       wr_ready = (cyc % 4 == 0);
        default: wr_ready = 1'b0;
      endcase
      #1;
      if (frame_done) done_count++;
      if (busy && !s_ready) ready_low++;
      if (rst && wr_en && wr_ready) begin
        wr_count++;
        if (exp_addr_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: waddr=%0d wdata=%0h with no pixel pending", waddr, wdata);
        end else begin
          chk("waddr", 32'(waddr), 32'(exp_addr_q.pop_front()));
          chk("wdata", 32'(wdata), 32'(exp_data_q.pop_front()));
        end
        last_waddr = int'(waddr);
      end
      if (cyc > 95000) begin
        $display("FAIL cycle_budget: %0d cycles used, limit 95000", cyc);
        $fatal(1, "cycle budget exhausted");
      end
    end
  end

  task automatic send(input logic [11:0] d, input bit sof, input bit eol, input bit gaps);
    bit acc;
    int tries = 0;
    if (gaps && $urandom_range(3) == 0) @(negedge clk);
    @(negedge clk);
    s_valid = 1'b1; s_data = d; s_sof = sof; s_eol = eol;
    forever begin
      #2 acc = s_ready;
      @(posedge clk);
      if (acc) break;
      tries++;
      if (tries > 200) begin
        n_total++;
        $display("FAIL beat_accept: s_ready stayed 0 for %0d cycles, needed 1", tries);
        break;
      end
      @(negedge clk);
    end
    if (acc) model_beat(d, sof, eol);
    #1 s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
  endtask

  task automatic send_row(input int n, input bit sof, input bit eol, input bit gaps);
    for (int i = 0; i < n; i++) send(12'($urandom), sof && i == 0, eol && i == n - 1, gaps);
  endtask

  task automatic send_frame(input bit gaps);
    for (int r = 0; r < LINES; r++) send_row(H, r == 0, 1'b1, gaps);
  endtask

  task automatic arm_pulse();
    @(negedge clk); arm = 1'b1; if (!m_cap) m_armed = 1'b1;
    @(negedge clk); arm = 1'b0;
  endtask

  task automatic wait_drain(input string name, input bit need_idle);
    int t = 0;
    while ((exp_addr_q.size() != 0 || wr_en || (need_idle && busy)) && t < 4000) begin
      @(negedge clk); t++;
    end
    @(negedge clk); #3;
    chk(name, 32'(exp_addr_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_errs", 32'({err_short, err_long, err_frame, frame_done}), 32'd0);
    exp_addr_q.delete(); exp_data_q.delete();
    m_cap = 0; m_armed = 0; m_short = 0; m_long = 0; m_frame = 0; m_r = 0; m_c = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_armed = continuous;
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    m_short = 0; m_long = 0; m_frame = 0;
  endtask

  task automatic chk_errs(input string name);
    chk({name, "_short"}, 32'(err_short), 32'(m_short));
    chk({name, "_long"},  32'(err_long),  32'(m_long));
    chk({name, "_frame"}, 32'(err_frame), 32'(m_frame));
  endtask

  initial begin
    int wc0, d0, r0;
    rst = 0; arm = 0; continuous = 0; s_valid = 0; s_sof = 0; s_eol = 0; clr_err = 0;
    s_data = '0; wr_ready = 0;
    repeat (3) @(negedge clk);
    #3;
    chk("reset_s_ready", 32'(s_ready), 32'd0);
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_waddr", 32'(waddr), 32'd0);
    chk("reset_wdata", 32'(wdata), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_flags", 32'({frame_done, err_short, err_long, err_frame}), 32'd0);
    chk("pix_addr_row1", 32'(pix_addr(9'd1, 10'd0)), 32'd640);
    chk("pix_addr_max", 32'(pix_addr(9'd479, 10'd639)), 32'd307199);
    @(negedge clk); rst = 1'b1;

    // Control table: IDLE discard, arm, WAIT_SOF discard, sof capture, FIFO fill to full
    vt[0] = '{0, 0, 0, 1, 0, 0};
    vt[1] = '{0, 1, 1, 1, 0, 0};
    vt[2] = '{1, 0, 0, 1, 1, 0};
    vt[3] = '{0, 1, 0, 1, 1, 0};
    vt[4] = '{1, 1, 0, 1, 1, 0};
    vt[5] = '{0, 1, 1, 1, 1, 1};
    vt[6] = '{0, 1, 0, 1, 1, 1};
    vt[7] = '{0, 1, 0, 1, 1, 1};
    vt[8] = '{0, 1, 0, 1, 1, 1};
    vt[9] = '{0, 1, 0, 0, 1, 1};
    wr_mode = 2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      arm = vt[i].arm; s_valid = vt[i].valid; s_sof = vt[i].sof; s_eol = 1'b0;
      s_data = 12'($urandom);
      if (vt[i].arm && !m_cap) m_armed = 1'b1;
      #2 chk($sformatf("vec%0d_s_ready", i), 32'(s_ready), 32'(vt[i].exp_ready));
      @(posedge clk);
      if (vt[i].valid && vt[i].exp_ready) model_beat(s_data, vt[i].sof, 1'b0);
      #1 arm = 1'b0; s_valid = 1'b0; s_sof = 1'b0;
      #1;
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].exp_busy));
      chk($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'(vt[i].exp_wr));
    end
    wr_mode = 0;
    wait_drain("table_drain", 1'b0);
    chk("table_last_waddr", 32'(last_waddr), 32'd3);
    do_reset();

    // Full frame, wr_ready always high, random input gaps
    wc0 = wr_count; d0 = done_count;
    arm_pulse();
    send_frame(1'b1);
    wait_drain("frame_drain", 1'b1);
    chk("frame_writes", 32'(wr_count - wc0), 32'(H * LINES));
    chk("frame_last_waddr", 32'(last_waddr), 32'(H * LINES - 1));
    chk("frame_done_pulses", 32'(done_count - d0), 32'd1);
    chk("frame_busy_end", 32'(busy), 32'd0);
    chk_errs("frame_err");

    // Backpressure: wr_ready high one cycle in four
    wr_mode = 1; r0 = ready_low; wc0 = wr_count;
    arm_pulse();
    send_row(H, 1'b1, 1'b1, 1'b0);
    send_row(H, 1'b0, 1'b1, 1'b0);
    send_row(10, 1'b0, 1'b0, 1'b0);
    wait_drain("bp_drain", 1'b0);
    chk("bp_ready_dropped", 32'(ready_low > r0), 32'd1);
    chk("bp_writes", 32'(wr_count - wc0), 32'(2 * H + 10));
    chk("bp_last_waddr", 32'(last_waddr), 32'(2 * H + 9));
    wr_mode = 0;
    do_reset();

    // Short line: eol at col 99 of row 2
    arm_pulse();
    send_row(H, 1'b1, 1'b1, 1'b1);
    send_row(H, 1'b0, 1'b1, 1'b1);
    send_row(100, 1'b0, 1'b1, 1'b1);
    send_row(1, 1'b0, 1'b0, 1'b0);
    wait_drain("short_drain", 1'b0);
    chk("short_err", 32'(err_short), 32'd1);
    chk("short_next_waddr", 32'(last_waddr), 32'd1920);
    chk_errs("short_errs");
    pulse_clr();
    #1 chk("short_cleared", 32'(err_short), 32'd0);
    do_reset();

    // Long line: 700 beats on row 0, eol on the last
    wc0 = wr_count;
    arm_pulse();
    send_row(700, 1'b1, 1'b1, 1'b0);
    send_row(1, 1'b0, 1'b0, 1'b0);
    wait_drain("long_drain", 1'b0);
    chk("long_err", 32'(err_long), 32'd1);
    chk("long_writes", 32'(wr_count - wc0), 32'(H + 1));
    chk("long_row1_waddr", 32'(last_waddr), 32'd640);
    chk_errs("long_errs");
    do_reset();

    // sof at row 10 col 5, then clr_err in the same cycle as a fresh sof error
    arm_pulse();
    for (int r = 0; r < 10; r++) send_row(H, r == 0, 1'b1, 1'b1);
    send_row(5, 1'b0, 1'b0, 1'b0);
    send(12'($urandom), 1'b1, 1'b0, 1'b0);
    wait_drain("sof_drain", 1'b0);
    chk("sof_err_frame", 32'(err_frame), 32'd1);
    chk("sof_restart_waddr", 32'(last_waddr), 32'd0);
    clr_err = 1'b1; m_short = 0; m_long = 0; m_frame = 0;
    send(12'($urandom), 1'b1, 1'b0, 1'b0);
    clr_err = 1'b0;
    #1 chk("clr_vs_new_err", 32'(err_frame), 32'd1);
    pulse_clr();
    #1 chk("sof_err_cleared", 32'(err_frame), 32'd0);
    wait_drain("sof_drain2", 1'b0);
    chk_errs("sof_errs");
    do_reset();

    // Continuous: two frames with no arm, then reset in the middle of a third
    continuous = 1'b1; m_armed = 1'b1; d0 = done_count;
    send_frame(1'b0);
    send_frame(1'b0);
    wait_drain("cont_drain", 1'b0);
    repeat (3) @(negedge clk);
    chk("cont_done_pulses", 32'(done_count - d0), 32'd2);
    chk("cont_busy", 32'(busy), 32'd1);
    wr_mode = 1;
    send_row(50, 1'b1, 1'b0, 1'b0);
    do_reset();
    wr_mode = 0; wc0 = wr_count;
    send_row(20, 1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    chk("post_reset_no_writes", 32'(wr_count - wc0), 32'd0);
    send(12'($urandom), 1'b1, 1'b0, 1'b0);
    wait_drain("post_reset_drain", 1'b0);
    chk("post_reset_sof_writes", 32'(wr_count - wc0), 32'd1);
    chk("post_reset_sof_waddr", 32'(last_waddr), 32'd0);
    continuous = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
